// File: rtl/i2c_slave_write_receiver_if.sv
// ----------------------------------------------------------------------------
// i2c_slave_write_receiver_if
// Groups the sampled I2C bus lines, the enable input and every result output of
// the I2C slave write receiver into one bundle.
//
// Signals:
//   enable      block active; low forces the receiver back to idle
//   SCL         synchronised SCL, current sample
//   SCL_prev    SCL sample from the previous system clock
//   SDA         synchronised SDA, current sample
//   SDA_prev    SDA sample from the previous system clock
//   SDA_down    1 = pull SDA low (open-drain ACK)
//   busy        1 while this slave is addressed
//   done        1-cycle pulse: a matched write ended with STOP
//   byte_valid  1-cycle pulse: byte_out was just stored
//   byte_out    last stored byte
//   rx_count    number of bytes stored in the current transaction
//   rx_data     stored bytes, byte k at [8k+7:8k]
//   overflow    a byte beyond NUM_BYTES was refused in this transaction
//
// Modports:
//   slave   used by the receiver (bus lines in, results out)
//   master  used by whatever drives the bus lines and consumes the results
// ----------------------------------------------------------------------------
interface i2c_slave_write_receiver_if #(
    parameter int NUM_BYTES = 6
);
    localparam int CW = $clog2(NUM_BYTES + 1);

    logic                   enable;
    logic                   SCL;
    logic                   SCL_prev;
    logic                   SDA;
    logic                   SDA_prev;
    logic                   SDA_down;
    logic                   busy;
    logic                   done;
    logic                   byte_valid;
    logic [7:0]             byte_out;
    logic [CW-1:0]          rx_count;
    logic [NUM_BYTES*8-1:0] rx_data;
    logic                   overflow;

    modport slave (
        input  enable, SCL, SCL_prev, SDA, SDA_prev,
        output SDA_down, busy, done, byte_valid, byte_out, rx_count, rx_data, overflow
    );

    modport master (
        output enable, SCL, SCL_prev, SDA, SDA_prev,
        input  SDA_down, busy, done, byte_valid, byte_out, rx_count, rx_data, overflow
    );
endinterface

// File: rtl/i2c_slave_write_receiver.sv
// ----------------------------------------------------------------------------
// i2c_slave_write_receiver
// I2C slave write path. Detects START/STOP from the current and previous
// SCL/SDA samples, receives the 7-bit address plus R/W bit, ACKs when the
// address matches a write, then stores up to NUM_BYTES data bytes (ACKing each)
// into a flat bus with the first received byte in the lowest bits.
//
// Ports:
//   FPGA_clk  system clock, all logic on the rising edge
//   rst       synchronous active-high reset
//   bus       i2c_slave_write_receiver_if.slave bundle (bus samples in,
//             SDA_down / status / received data out)
//
// Parameters:
//   NUM_BYTES       maximum data bytes stored per transaction (>= 1)
//   SLAVE_ADDR      7-bit address this slave answers to
//   CLEAR_ON_START  1: zero rx_data/rx_count on address match, 0: keep them
// ----------------------------------------------------------------------------
module i2c_slave_write_receiver #(
    parameter int         NUM_BYTES      = 6,
    parameter logic [6:0] SLAVE_ADDR     = 7'h42,
    parameter bit         CLEAR_ON_START = 1'b1
) (
    input  logic                     FPGA_clk,
    input  logic                     rst,
    i2c_slave_write_receiver_if.slave bus
);
    localparam int            CW        = $clog2(NUM_BYTES + 1);
    localparam logic [CW-1:0] MAX_COUNT = CW'(NUM_BYTES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_DATA,
        S_DATA_ACK,
        S_IGNORE
    } stateT;

    stateT                  r_state;
    logic [7:0]             r_shift;
    logic [2:0]             r_bitCnt;
    logic                   r_matched;
    logic                   r_ackDriven;
    logic                   r_sdaDown;
    logic                   r_done;
    logic                   r_byteValid;
    logic [7:0]             r_byteOut;
    logic [CW-1:0]          r_rxCount;
    logic [NUM_BYTES*8-1:0] r_rxData;
    logic                   r_overflow;

    stateT                  w_stateNext;
    logic [7:0]             w_shiftNext;
    logic [2:0]             w_bitCntNext;
    logic                   w_matchedNext;
    logic                   w_ackDrivenNext;
    logic                   w_sdaDownNext;
    logic                   w_doneNext;
    logic                   w_byteValidNext;
    logic [7:0]             w_byteOutNext;
    logic [CW-1:0]          w_rxCountNext;
    logic [NUM_BYTES*8-1:0] w_rxDataNext;
    logic                   w_overflowNext;

    logic                   w_sclRise;
    logic                   w_sclFall;
    logic                   w_start;
    logic                   w_stop;
    logic [7:0]             w_byte;
    logic                   w_byteDone;

    // Bus events. START/STOP are SDA edges while SCL stays high; they are
    // checked before any SCL edge in the next-state logic so they win.
    assign w_sclRise  = bus.SCL & ~bus.SCL_prev;
    assign w_sclFall  = ~bus.SCL & bus.SCL_prev;
    assign w_start    = bus.SCL & bus.SCL_prev & bus.SDA_prev & ~bus.SDA;
    assign w_stop     = bus.SCL & bus.SCL_prev & ~bus.SDA_prev & bus.SDA;

    // The byte as it will look once the current SDA sample is shifted in;
    // it is complete when this rise is the eighth one of the byte.
    assign w_byte     = {r_shift[6:0], bus.SDA};
    assign w_byteDone = (r_bitCnt == 3'd7);

    // Next-state and next-output logic. Every register holds by default and
    // the two pulses default low; disable, START and STOP override the
    // per-state behaviour. The ACK states use r_ackDriven to tell the SCL fall
    // that starts the ACK bit (pull SDA low) from the one that ends it
    // (release SDA and go back to receiving data).
    always_comb begin
        w_stateNext     = r_state;
        w_shiftNext     = r_shift;
        w_bitCntNext    = r_bitCnt;
        w_matchedNext   = r_matched;
        w_ackDrivenNext = r_ackDriven;
        w_sdaDownNext   = r_sdaDown;
        w_doneNext      = 1'b0;
        w_byteValidNext = 1'b0;
        w_byteOutNext   = r_byteOut;
        w_rxCountNext   = r_rxCount;
        w_rxDataNext    = r_rxData;
        w_overflowNext  = r_overflow;

        if (!bus.enable) begin
            w_stateNext     = S_IDLE;
            w_sdaDownNext   = 1'b0;
            w_matchedNext   = 1'b0;
            w_ackDrivenNext = 1'b0;
            w_overflowNext  = 1'b0;
            w_bitCntNext    = 3'd0;
        end else if (w_start) begin
            w_stateNext     = S_ADDR;
            w_bitCntNext    = 3'd0;
            w_sdaDownNext   = 1'b0;
            w_matchedNext   = 1'b0;
            w_ackDrivenNext = 1'b0;
            w_overflowNext  = 1'b0;
        end else if (w_stop) begin
            w_stateNext     = S_IDLE;
            w_sdaDownNext   = 1'b0;
            w_doneNext      = r_matched;
            w_matchedNext   = 1'b0;
            w_ackDrivenNext = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                end
                S_ADDR: begin
                    if (w_sclRise) begin
                        w_shiftNext  = w_byte;
                        w_bitCntNext = r_bitCnt + 3'd1;
                        if (w_byteDone) begin
                            if (w_byte[7:1] == SLAVE_ADDR && !w_byte[0]) begin
                                w_stateNext   = S_ADDR_ACK;
                                w_matchedNext = 1'b1;
                                if (CLEAR_ON_START) begin
                                    w_rxCountNext = '0;
                                    w_rxDataNext  = '0;
                                end
                            end else begin
                                w_stateNext = S_IGNORE;
                            end
                        end
                    end
                end
                S_ADDR_ACK, S_DATA_ACK: begin
                    if (w_sclFall) begin
                        if (!r_ackDriven) begin
                            w_sdaDownNext   = 1'b1;
                            w_ackDrivenNext = 1'b1;
                        end else begin
                            w_sdaDownNext   = 1'b0;
                            w_ackDrivenNext = 1'b0;
                            w_bitCntNext    = 3'd0;
                            w_stateNext     = S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (w_sclRise) begin
                        w_shiftNext  = w_byte;
                        w_bitCntNext = r_bitCnt + 3'd1;
                        if (w_byteDone) begin
                            if (r_rxCount < MAX_COUNT) begin
                                for (int k = 0; k < NUM_BYTES; k++) begin
                                    if (k == int'(r_rxCount)) begin
                                        w_rxDataNext[k*8 +: 8] = w_byte;
                                    end
                                end
                                w_rxCountNext   = r_rxCount + CW'(1);
                                w_byteOutNext   = w_byte;
                                w_byteValidNext = 1'b1;
                                w_stateNext     = S_DATA_ACK;
                            end else begin
                                w_overflowNext = 1'b1;
                                w_stateNext    = S_IGNORE;
                            end
                        end
                    end
                end
                S_IGNORE: begin
                    w_sdaDownNext = 1'b0;
                end
                default: begin
                    w_stateNext = S_IDLE;
                end
            endcase
        end
    end

    // State register. Reset clears everything including the stored data,
    // which the disable path above deliberately keeps.
    always_ff @(posedge FPGA_clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_shift     <= 8'd0;
            r_bitCnt    <= 3'd0;
            r_matched   <= 1'b0;
            r_ackDriven <= 1'b0;
            r_sdaDown   <= 1'b0;
            r_done      <= 1'b0;
            r_byteValid <= 1'b0;
            r_byteOut   <= 8'd0;
            r_rxCount   <= '0;
            r_rxData    <= '0;
            r_overflow  <= 1'b0;
        end else begin
            r_state     <= w_stateNext;
            r_shift     <= w_shiftNext;
            r_bitCnt    <= w_bitCntNext;
            r_matched   <= w_matchedNext;
            r_ackDriven <= w_ackDrivenNext;
            r_sdaDown   <= w_sdaDownNext;
            r_done      <= w_doneNext;
            r_byteValid <= w_byteValidNext;
            r_byteOut   <= w_byteOutNext;
            r_rxCount   <= w_rxCountNext;
            r_rxData    <= w_rxDataNext;
            r_overflow  <= w_overflowNext;
        end
    end

    // Outputs come straight from registers; busy only needs the match flag
    // qualified by the state.
    assign bus.SDA_down   = r_sdaDown;
    assign bus.busy       = r_matched && (r_state != S_IDLE);
    assign bus.done       = r_done;
    assign bus.byte_valid = r_byteValid;
    assign bus.byte_out   = r_byteOut;
    assign bus.rx_count   = r_rxCount;
    assign bus.rx_data    = r_rxData;
    assign bus.overflow   = r_overflow;
endmodule

// File: tb/tb_i2c_slave_write_receiver.sv
// ----------------------------------------------------------------------------
// tb_i2c_slave_write_receiver
// Bit-level I2C master driving the write receiver through its interface, with
// a transaction-level model of what the slave must store and acknowledge.
// Expected byte_valid and done events are queued as bytes are sent; a monitor
// pops them whenever the DUT pulses those outputs.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_i2c_slave_write_receiver;
    localparam int NUM_BYTES = 6;
    localparam int CW        = $clog2(NUM_BYTES + 1);
    localparam logic [7:0] WRITE_ADDR = 8'h84;

    typedef struct {
        logic [7:0] b;
        int         cnt;
    } byteEvT;

    typedef struct {
        int                     cnt;
        logic [NUM_BYTES*8-1:0] data;
    } doneEvT;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    byteEvT expByteQ[$];
    doneEvT expDoneQ[$];

    // Transaction-level picture of the slave: stored bytes, and whether the
    // current transfer is addressed to it and still being accepted.
    logic [7:0] mData [NUM_BYTES];
    int         mCount;
    bit         mMatched;
    bit         mRefusing;

    i2c_slave_write_receiver_if #(.NUM_BYTES(NUM_BYTES)) bus ();

    i2c_slave_write_receiver #(
        .NUM_BYTES(NUM_BYTES),
        .SLAVE_ADDR(7'h42),
        .CLEAR_ON_START(1'b1)
    ) dut (
        .FPGA_clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Previous-sample stage that sits in front of the receiver.
    always @(posedge clk) begin
        bus.SCL_prev <= bus.SCL;
        bus.SDA_prev <= bus.SDA;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    function automatic logic [NUM_BYTES*8-1:0] packData();
        logic [NUM_BYTES*8-1:0] p;
        p = '0;
        for (int k = 0; k < NUM_BYTES; k++) p[k*8 +: 8] = mData[k];
        return p;
    endfunction

    task automatic clearModelData();
        mCount = 0;
        for (int k = 0; k < NUM_BYTES; k++) mData[k] = 8'h00;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sendBit(input logic b);
        bus.SDA = b;
        waitCycles(2);
        bus.SCL = 1'b1;
        waitCycles(3);
        bus.SCL = 1'b0;
        waitCycles(2);
    endtask

    task automatic sendPartial(input int n);
        for (int i = 0; i < n; i++) sendBit(1'($urandom_range(0, 1)));
    endtask

    task automatic startCond();
        bus.SDA = 1'b1;
        waitCycles(2);
        bus.SCL = 1'b1;
        waitCycles(3);
        bus.SDA = 1'b0;
        waitCycles(3);
        bus.SCL = 1'b0;
        waitCycles(2);
        mMatched  = 1'b0;
        mRefusing = 1'b0;
    endtask

    task automatic stopCond();
        doneEvT d;
        bus.SDA = 1'b0;
        waitCycles(2);
        bus.SCL = 1'b1;
        waitCycles(3);
        if (mMatched) begin
            d.cnt  = mCount;
            d.data = packData();
            expDoneQ.push_back(d);
        end
        mMatched = 1'b0;
        bus.SDA  = 1'b1;
        waitCycles(4);
    endtask

    task automatic ackSlot(input logic expAck);
        bus.SDA = 1'b1;
        waitCycles(2);
        checkOutput("ackSetup", 64'(bus.SDA_down), 64'(expAck));
        bus.SCL = 1'b1;
        waitCycles(3);
        checkOutput("ackHeld", 64'(bus.SDA_down), 64'(expAck));
        bus.SCL = 1'b0;
        waitCycles(2);
        checkOutput("ackRelease", 64'(bus.SDA_down), 64'(0));
    endtask

    // Sends one byte MSB first; the model decides up front whether the slave
    // must ACK it and what it must store.
    task automatic applyStimulus(input logic [7:0] b, input bit isAddr, input bit withAck);
        logic   expAck;
        byteEvT e;
        expAck = 1'b0;
        if (isAddr) begin
            if (b == WRITE_ADDR) begin
                expAck   = 1'b1;
                mMatched = 1'b1;
                clearModelData();
            end else begin
                mRefusing = 1'b1;
            end
        end else if (mMatched && !mRefusing) begin
            if (mCount < NUM_BYTES) begin
                mData[mCount] = b;
                mCount++;
                e.b   = b;
                e.cnt = mCount;
                expByteQ.push_back(e);
                expAck = 1'b1;
            end else begin
                mRefusing = 1'b1;
            end
        end
        for (int i = 7; i >= 0; i--) sendBit(b[i]);
        if (withAck) ackSlot(expAck);
    endtask

    // Scoreboard monitor: every pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (bus.byte_valid === 1'b1) begin
            checkOutput("byteValidQueued", 64'(expByteQ.size() > 0), 64'(1));
            if (expByteQ.size() > 0) begin
                byteEvT e;
                e = expByteQ.pop_front();
                checkOutput("byteOut", 64'(bus.byte_out), 64'(e.b));
                checkOutput("rxCountAtByte", 64'(bus.rx_count), 64'(e.cnt));
            end
        end
        if (bus.done === 1'b1) begin
            checkOutput("doneQueued", 64'(expDoneQ.size() > 0), 64'(1));
            if (expDoneQ.size() > 0) begin
                doneEvT d;
                d = expDoneQ.pop_front();
                checkOutput("rxCountAtDone", 64'(bus.rx_count), 64'(d.cnt));
                checkOutput("rxDataAtDone", 64'(bus.rx_data), 64'(d.data));
            end
        end
    end

    initial begin
        logic [7:0] dirBytes [6];
        logic [7:0] addrByte;
        int         nBytes;
        int         endKind;

        errors = 0;
        checks = 0;
        mMatched  = 1'b0;
        mRefusing = 1'b0;
        clearModelData();
        dirBytes = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB};

        rst        = 1'b1;
        bus.enable = 1'b1;
        bus.SCL    = 1'b1;
        bus.SDA    = 1'b1;
        waitCycles(4);
        checkOutput("resetSdaDown", 64'(bus.SDA_down), 64'(0));
        checkOutput("resetBusy", 64'(bus.busy), 64'(0));
        checkOutput("resetDone", 64'(bus.done), 64'(0));
        checkOutput("resetRxCount", 64'(bus.rx_count), 64'(0));
        checkOutput("resetRxData", 64'(bus.rx_data), 64'(0));
        checkOutput("resetOverflow", 64'(bus.overflow), 64'(0));
        rst = 1'b0;
        waitCycles(4);

        $display("[TB] matched write of six bytes");
        startCond();
        applyStimulus(WRITE_ADDR, 1'b1, 1'b1);
        checkOutput("busyAfterMatch", 64'(bus.busy), 64'(1));
        for (int i = 0; i < 6; i++) applyStimulus(dirBytes[i], 1'b0, 1'b1);
        stopCond();
        checkOutput("rxDataDirected", 64'(bus.rx_data), 64'h0000_AB89_6745_2301);
        checkOutput("rxCountDirected", 64'(bus.rx_count), 64'(6));
        checkOutput("busyAfterStop", 64'(bus.busy), 64'(0));

        $display("[TB] other address, then read request");
        startCond();
        applyStimulus(8'h86, 1'b1, 1'b1);
        checkOutput("busyMismatch", 64'(bus.busy), 64'(0));
        applyStimulus(8'h5A, 1'b0, 1'b1);
        applyStimulus(8'hC3, 1'b0, 1'b1);
        stopCond();
        checkOutput("rxDataKept", 64'(bus.rx_data), 64'h0000_AB89_6745_2301);
        checkOutput("rxCountKept", 64'(bus.rx_count), 64'(6));
        startCond();
        applyStimulus(8'h85, 1'b1, 1'b1);
        checkOutput("busyRead", 64'(bus.busy), 64'(0));
        applyStimulus(8'h77, 1'b0, 1'b1);
        stopCond();

        $display("[TB] overflow with one byte too many");
        startCond();
        applyStimulus(WRITE_ADDR, 1'b1, 1'b1);
        for (int i = 0; i < NUM_BYTES + 1; i++) applyStimulus(8'($urandom), 1'b0, 1'b1);
        checkOutput("overflowSet", 64'(bus.overflow), 64'(1));
        stopCond();
        checkOutput("overflowHeldAfterStop", 64'(bus.overflow), 64'(1));
        checkOutput("rxCountFull", 64'(bus.rx_count), 64'(NUM_BYTES));
        startCond();
        checkOutput("overflowClearedByStart", 64'(bus.overflow), 64'(0));
        applyStimulus(8'h86, 1'b1, 1'b1);
        stopCond();

        $display("[TB] STOP and repeated START mid-byte");
        startCond();
        applyStimulus(WRITE_ADDR, 1'b1, 1'b1);
        applyStimulus(8'h3E, 1'b0, 1'b1);
        sendPartial(4);
        stopCond();
        checkOutput("rxCountPartialStop", 64'(bus.rx_count), 64'(1));
        startCond();
        applyStimulus(WRITE_ADDR, 1'b1, 1'b1);
        applyStimulus(8'hE1, 1'b0, 1'b1);
        sendPartial(3);
        startCond();
        checkOutput("busyAfterRepStart", 64'(bus.busy), 64'(0));
        checkOutput("rxCountAfterRepStart", 64'(bus.rx_count), 64'(1));
        applyStimulus(WRITE_ADDR, 1'b1, 1'b1);
        applyStimulus(8'h12, 1'b0, 1'b1);
        applyStimulus(8'h34, 1'b0, 1'b1);
        stopCond();

        $display("[TB] randomized transactions");
        for (int t = 0; t < 30; t++) begin
            addrByte = ($urandom_range(0, 2) == 0) ? 8'($urandom) : WRITE_ADDR;
            nBytes   = $urandom_range(0, 8);
            endKind  = $urandom_range(0, 3);
            startCond();
            applyStimulus(addrByte, 1'b1, 1'b1);
            for (int i = 0; i < nBytes; i++) applyStimulus(8'($urandom), 1'b0, 1'b1);
            if (endKind >= 2) sendPartial($urandom_range(1, 6));
            if (endKind != 3) stopCond();
            checkOutput("rxCountRandom", 64'(bus.rx_count), 64'(mCount));
            checkOutput("rxDataRandom", 64'(bus.rx_data), 64'(packData()));
        end

        $display("[TB] reset while driving ACK");
        startCond();
        applyStimulus(WRITE_ADDR, 1'b1, 1'b1);
        applyStimulus(8'h5A, 1'b0, 1'b0);
        checkOutput("ackDrivenBeforeReset", 64'(bus.SDA_down), 64'(1));
        rst = 1'b1;
        waitCycles(1);
        rst = 1'b0;
        mMatched = 1'b0;
        clearModelData();
        checkOutput("sdaDownAfterReset", 64'(bus.SDA_down), 64'(0));
        checkOutput("busyAfterReset", 64'(bus.busy), 64'(0));
        checkOutput("rxCountAfterReset", 64'(bus.rx_count), 64'(0));
        checkOutput("rxDataAfterReset", 64'(bus.rx_data), 64'(0));
        checkOutput("byteOutAfterReset", 64'(bus.byte_out), 64'(0));
        stopCond();

        $display("[TB] disable while driving ACK");
        startCond();
        applyStimulus(WRITE_ADDR, 1'b1, 1'b1);
        applyStimulus(8'h3C, 1'b0, 1'b0);
        checkOutput("ackDrivenBeforeDisable", 64'(bus.SDA_down), 64'(1));
        bus.enable = 1'b0;
        waitCycles(1);
        mMatched = 1'b0;
        checkOutput("sdaDownAfterDisable", 64'(bus.SDA_down), 64'(0));
        checkOutput("busyAfterDisable", 64'(bus.busy), 64'(0));
        checkOutput("rxCountAfterDisable", 64'(bus.rx_count), 64'(mCount));
        checkOutput("rxDataAfterDisable", 64'(bus.rx_data), 64'(packData()));
        bus.enable = 1'b1;
        waitCycles(1);
        stopCond();

        waitCycles(10);
        checkOutput("byteEventsOutstanding", 64'(expByteQ.size()), 64'(0));
        checkOutput("doneEventsOutstanding", 64'(expDoneQ.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
